// File: rtl/fejkon_fc_capture_pkg.sv
// rtl/fejkon_fc_capture_pkg.sv - shared constants and types for the FC capture sink
package fejkon_fc_capture_pkg;

  localparam int CAP_BEATS  = 8;
  localparam int BEAT_BYTES = 32;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_ERRCNT = 8'h02;
  localparam logic [7:0] ADDR_PKT0   = 8'h04;
  localparam logic [7:0] ADDR_BYTES0 = 8'h08;
  localparam logic [7:0] ADDR_CLEAR  = 8'h0C;
  localparam logic [7:0] ADDR_CAPBUF = 8'h40;

  typedef enum logic [1:0] {
    CAP_IDLE  = 2'd0,
    CAP_ARMED = 2'd1,
    CAP_CAP   = 2'd2,
    CAP_DONE  = 2'd3
  } cap_state_e;

endpackage

// File: rtl/fejkon_fc_capture_if.sv
// rtl/fejkon_fc_capture_if.sv - 256-bit, 4-channel Avalon-ST stream bundle
interface fejkon_fc_capture_if;
  import fejkon_fc_capture_pkg::*;

  logic [1:0]              channel;
  logic [8*BEAT_BYTES-1:0] data;
  logic                    startofpacket;
  logic                    endofpacket;
  logic [4:0]              empty;
  logic                    valid;
  logic                    ready;

  modport master (
    output channel, data, startofpacket, endofpacket, empty, valid,
    input  ready
  );

  modport slave (
    input  channel, data, startofpacket, endofpacket, empty, valid,
    output ready
  );

endinterface

// File: rtl/fejkon_fc_capture_buf.sv
// rtl/fejkon_fc_capture_buf.sv - 8x256 capture store with a 32-bit word read mux
module fejkon_fc_capture_buf
  import fejkon_fc_capture_pkg::*;
(
  input  logic                    clk,
  input  logic                    we,
  input  logic [2:0]              waddr,
  input  logic [8*BEAT_BYTES-1:0] wdata,
  input  logic [5:0]              raddr,
  output logic [31:0]             rdata
);

  logic [8*BEAT_BYTES-1:0] mem [CAP_BEATS];
  logic [8*BEAT_BYTES-1:0] row;
  logic [8*BEAT_BYTES-1:0] row_shifted;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Word 0 is the most significant 32 bits of the beat.
  always_comb begin
    row         = mem[raddr[5:3]];
    row_shifted = row << {raddr[2:0], 5'd0};
    rdata       = row_shifted[8*BEAT_BYTES-1 -: 32];
  end

endmodule

// File: rtl/fejkon_fc_capture.sv
// rtl/fejkon_fc_capture.sv - FC stream sink/monitor: forward or drop, counters, packet capture
module fejkon_fc_capture
  import fejkon_fc_capture_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  fejkon_fc_capture_if.slave         st_in,
  fejkon_fc_capture_if.master        st_out,
  input  logic [7:0]                 csr_address,
  input  logic                       csr_write,
  input  logic                       csr_read,
  input  logic [31:0]                csr_writedata,
  output logic [31:0]                csr_readdata
);

  localparam logic [1:0] S_IDLE  = CAP_IDLE;
  localparam logic [1:0] S_ARMED = CAP_ARMED;
  localparam logic [1:0] S_CAP   = CAP_CAP;
  localparam logic [1:0] S_DONE  = CAP_DONE;

  logic        ctrl_drop, filt_en;
  logic [1:0]  filt_ch;
  logic        in_pkt, drop_lat, drop_eff;
  logic        accept, proto_err, ctrl_wr, clr, cap_hit;
  logic [5:0]  beat_bytes;
  logic [15:0] errcnt;
  logic [31:0] pkt_cnt  [4];
  logic [31:0] byte_cnt [4];

  logic [1:0]  state;
  logic [3:0]  cap_cnt;
  logic [4:0]  cap_empty;
  logic [1:0]  cap_ch;
  logic        cap_trunc;

  logic        buf_we;
  logic [2:0]  buf_waddr;
  logic [31:0] buf_rdata;
  logic [31:0] rd_mux;

  logic                    out_valid, out_sop, out_eop;
  logic [1:0]              out_channel;
  logic [4:0]              out_empty;
  logic [8*BEAT_BYTES-1:0] out_data;

  logic unused_wd;
  assign unused_wd = ^{csr_writedata[31:6], csr_writedata[3]};

  // A packet's mode is fixed by the DROP value seen at its SOP.
  assign drop_eff = (~in_pkt | st_in.startofpacket) ? ctrl_drop : drop_lat;
  assign st_in.ready = ~reset & (drop_eff | ~out_valid | st_out.ready);
  assign accept    = st_in.valid & st_in.ready;
  assign proto_err = st_in.startofpacket ? in_pkt : ~in_pkt;
  assign ctrl_wr   = csr_write & (csr_address == ADDR_CTRL);
  assign clr       = csr_write & (csr_address == ADDR_CLEAR);
  assign beat_bytes = st_in.endofpacket ? (6'(BEAT_BYTES) - {1'b0, st_in.empty})
                                        : 6'(BEAT_BYTES);

  assign st_out.valid         = out_valid;
  assign st_out.channel       = out_channel;
  assign st_out.data          = out_data;
  assign st_out.startofpacket = out_sop;
  assign st_out.endofpacket   = out_eop;
  assign st_out.empty         = out_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_channel <= '0;
      out_data    <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_empty   <= '0;
    end else if (accept & ~drop_eff) begin
      out_valid   <= 1'b1;
      out_channel <= st_in.channel;
      out_data    <= st_in.data;
      out_sop     <= st_in.startofpacket;
      out_eop     <= st_in.endofpacket;
      out_empty   <= st_in.empty;
    end else if (st_out.ready) begin
      out_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_drop <= 1'b0;
      filt_en   <= 1'b0;
      filt_ch   <= '0;
      in_pkt    <= 1'b0;
      drop_lat  <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl_drop <= csr_writedata[1];
        filt_en   <= csr_writedata[2];
        filt_ch   <= csr_writedata[5:4];
      end
      if (accept) begin
        if (st_in.startofpacket) in_pkt <= ~st_in.endofpacket;
        else if (st_in.endofpacket) in_pkt <= 1'b0;
      end
      if ((accept & st_in.startofpacket) | ~in_pkt) drop_lat <= ctrl_drop;
    end
  end

  // CLEAR takes priority over the beat accepted in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      errcnt <= '0;
      for (int i = 0; i < 4; i++) begin
        pkt_cnt[i]  <= '0;
        byte_cnt[i] <= '0;
      end
    end else if (clr) begin
      errcnt <= '0;
      for (int i = 0; i < 4; i++) begin
        pkt_cnt[i]  <= '0;
        byte_cnt[i] <= '0;
      end
    end else if (accept) begin
      if (proto_err && errcnt != 16'hFFFF) errcnt <= errcnt + 16'd1;
      if (st_in.endofpacket) pkt_cnt[st_in.channel] <= pkt_cnt[st_in.channel] + 32'd1;
      byte_cnt[st_in.channel] <= byte_cnt[st_in.channel] + {26'd0, beat_bytes};
    end
  end

  assign cap_hit   = accept & st_in.startofpacket & (~filt_en | (st_in.channel == filt_ch));
  assign buf_we    = ((state == S_ARMED) & cap_hit) | ((state == S_CAP) & accept);
  assign buf_waddr = (state == S_CAP) ? cap_cnt[2:0] : 3'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cap_cnt   <= '0;
      cap_empty <= '0;
      cap_ch    <= '0;
      cap_trunc <= 1'b0;
    end else if (ctrl_wr) begin
      if (csr_writedata[0]) begin
        state     <= S_ARMED;
        cap_cnt   <= '0;
        cap_empty <= '0;
        cap_ch    <= '0;
        cap_trunc <= 1'b0;
      end else begin
        state <= S_IDLE;
      end
    end else begin
      case (state)
        S_ARMED: if (cap_hit) begin
          cap_cnt <= 4'd1;
          cap_ch  <= st_in.channel;
          if (st_in.endofpacket) begin
            state     <= S_DONE;
            cap_empty <= st_in.empty;
          end else begin
            state <= S_CAP;
          end
        end
        S_CAP: if (accept) begin
          cap_cnt <= cap_cnt + 4'd1;
          if (st_in.endofpacket) begin
            state     <= S_DONE;
            cap_empty <= st_in.empty;
          end else if (cap_cnt == 4'(CAP_BEATS - 1)) begin
            state     <= S_DONE;
            cap_trunc <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  fejkon_fc_capture_buf u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (st_in.data),
    .raddr (csr_address[5:0]),
    .rdata (buf_rdata)
  );

  always_comb begin
    rd_mux = 32'hFFFF_FFFF;
    if (csr_address[7:6] == ADDR_CAPBUF[7:6]) begin
      rd_mux = buf_rdata;
    end else if (csr_address[7:2] == ADDR_PKT0[7:2]) begin
      rd_mux = pkt_cnt[csr_address[1:0]];
    end else if (csr_address[7:2] == ADDR_BYTES0[7:2]) begin
      rd_mux = byte_cnt[csr_address[1:0]];
    end else begin
      case (csr_address)
        ADDR_CTRL:   rd_mux = {26'd0, filt_ch, 1'b0, filt_en, ctrl_drop,
                               (state == S_ARMED) | (state == S_CAP)};
        ADDR_STATUS: rd_mux = {11'd0, cap_trunc, 2'd0, cap_ch, 3'd0, cap_empty,
                               cap_cnt, 2'd0, state};
        ADDR_ERRCNT: rd_mux = {16'd0, errcnt};
        default:     rd_mux = 32'hFFFF_FFFF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csr_readdata <= '0;
    end else if (csr_read) begin
      csr_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_fejkon_fc_capture.sv
// tb/tb_fejkon_fc_capture.sv - directed scoreboard bench for fejkon_fc_capture
module tb_fejkon_fc_capture;
  import fejkon_fc_capture_pkg::*;

  typedef struct packed {
    logic [1:0]   ch;
    logic         sop;
    logic         eop;
    logic [4:0]   empty;
    logic [255:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  csr_address = 8'd0;
  logic        csr_write = 1'b0;
  logic        csr_read = 1'b0;
  logic [31:0] csr_writedata = 32'd0;
  logic [31:0] csr_readdata;

  fejkon_fc_capture_if st_in();
  fejkon_fc_capture_if st_out();

  beat_t sb[$];
  beat_t mon_obs, mon_exp;
  int checks = 0;
  int passes = 0;
  logic [255:0] d0, hold_data, cap;

  always #5 clk = ~clk;

  fejkon_fc_capture dut (
    .clk           (clk),
    .reset         (reset),
    .st_in         (st_in),
    .st_out        (st_out),
    .csr_address   (csr_address),
    .csr_write     (csr_write),
    .csr_read      (csr_read),
    .csr_writedata (csr_writedata),
    .csr_readdata  (csr_readdata)
  );

  always @(negedge clk) begin
    if (!reset && st_out.valid && st_out.ready) begin
      mon_obs = {st_out.channel, st_out.startofpacket, st_out.endofpacket, st_out.empty, st_out.data};
      checks++;
      assert (sb.size() != 0) passes++;
      else $error("FAIL sb_unexpected_beat observed=%h expected=none", mon_obs);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        checks++;
        assert (mon_obs === mon_exp) passes++;
        else $error("FAIL sb_beat observed=%h expected=%h", mon_obs, mon_exp);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [255:0] mk_data(input int seed);
    logic [255:0] d;
    for (int w = 0; w < 8; w++) d[255 - 32*w -: 32] = 32'h5A00_0000 ^ (32'(seed) << 8) ^ 32'(w);
    return d;
  endfunction

  task automatic present(input logic [1:0] ch, input logic [255:0] data,
                         input logic sop, input logic eop, input logic [4:0] empty);
    st_in.channel       = ch;
    st_in.data          = data;
    st_in.startofpacket = sop;
    st_in.endofpacket   = eop;
    st_in.empty         = empty;
    st_in.valid         = 1'b1;
  endtask

  task automatic wait_accept(input bit fwd);
    int n = 0;
    @(negedge clk);
    while (!st_in.ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(st_in.ready), 32'd1);
    if (fwd) sb.push_back({st_in.channel, st_in.startofpacket, st_in.endofpacket, st_in.empty, st_in.data});
    @(posedge clk);
    #1;
    st_in.valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] ch, input logic [255:0] data, input logic sop,
                      input logic eop, input logic [4:0] empty, input bit fwd);
    present(ch, data, sop, eop, empty);
    wait_accept(fwd);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [7:0] addr, input logic [31:0] data);
    csr_address   = addr;
    csr_writedata = data;
    csr_write     = 1'b1;
    @(posedge clk);
    #1;
    csr_write = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    csr_address = addr;
    csr_read    = 1'b1;
    @(posedge clk);
    #1;
    csr_read = 1'b0;
    chk(tag, csr_readdata, exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    st_in.channel = 2'd0; st_in.data = '0; st_in.startofpacket = 1'b0;
    st_in.endofpacket = 1'b0; st_in.empty = 5'd0; st_in.valid = 1'b0;
    st_out.ready = 1'b1;

    // Reset state
    @(negedge clk);
    st_in.valid = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(st_in.ready), 32'd0);
    chk("rst_out_valid", 32'(st_out.valid), 32'd0);
    chk("rst_readdata", csr_readdata, 32'd0);
    st_in.valid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    rd_chk("ctrl_reset", ADDR_CTRL, 32'd0);
    rd_chk("status_reset", ADDR_STATUS, 32'd0);

    // Forward: 3-beat ch1 packet, empty=4
    d0 = mk_data(1);
    send(2'd1, d0, 1'b1, 1'b0, 5'd0, 1'b1);
    chk("fwd_latency_valid", 32'(st_out.valid), 32'd1);
    chk("fwd_latency_word", st_out.data[31:0], d0[31:0]);
    send(2'd1, mk_data(2), 1'b0, 1'b0, 5'd0, 1'b1);
    send(2'd1, mk_data(3), 1'b0, 1'b1, 5'd4, 1'b1);
    idle(3);
    chk("fwd_sb_empty", 32'(sb.size()), 32'd0);
    rd_chk("pkt1", 8'h05, 32'd1);
    rd_chk("bytes1", 8'h09, 32'd92);

    // Backpressure mid-packet
    hold_data = mk_data(11);
    send(2'd3, mk_data(10), 1'b1, 1'b0, 5'd0, 1'b1);
    send(2'd3, hold_data, 1'b0, 1'b0, 5'd0, 1'b1);
    st_out.ready = 1'b0;
    present(2'd3, mk_data(12), 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(st_in.ready), 32'd0);
      chk("bp_out_hold", st_out.data[255:224], hold_data[255:224]);
    end
    @(posedge clk);
    #1;
    st_out.ready = 1'b1;
    wait_accept(1'b1);
    send(2'd3, mk_data(13), 1'b0, 1'b1, 5'd0, 1'b1);
    idle(3);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);
    rd_chk("pkt3", 8'h07, 32'd1);

    // Drop written mid-packet: current packet still forwarded, next two consumed
    send(2'd0, mk_data(20), 1'b1, 1'b0, 5'd0, 1'b1);
    csr_wr(ADDR_CTRL, 32'h2);
    send(2'd0, mk_data(21), 1'b0, 1'b0, 5'd0, 1'b1);
    send(2'd0, mk_data(22), 1'b0, 1'b1, 5'd0, 1'b1);
    send(2'd0, mk_data(23), 1'b1, 1'b0, 5'd0, 1'b0);
    chk("drop_out_valid_a", 32'(st_out.valid), 32'd0);
    send(2'd0, mk_data(24), 1'b0, 1'b1, 5'd8, 1'b0);
    send(2'd0, mk_data(25), 1'b1, 1'b0, 5'd0, 1'b0);
    send(2'd0, mk_data(26), 1'b0, 1'b1, 5'd31, 1'b0);
    chk("drop_out_valid_b", 32'(st_out.valid), 32'd0);
    csr_wr(ADDR_CTRL, 32'h0);
    idle(2);
    chk("drop_sb_empty", 32'(sb.size()), 32'd0);
    rd_chk("pkt0", 8'h04, 32'd3);
    rd_chk("bytes0", 8'h08, 32'd185);

    // Capture with channel filter, truncated 10-beat packet
    csr_wr(ADDR_CTRL, 32'h25);
    rd_chk("ctrl_armed", ADDR_CTRL, 32'h25);
    rd_chk("status_armed", ADDR_STATUS, 32'h1);
    send(2'd0, mk_data(30), 1'b1, 1'b0, 5'd0, 1'b1);
    send(2'd0, mk_data(31), 1'b0, 1'b1, 5'd0, 1'b1);
    rd_chk("status_filtered", ADDR_STATUS, 32'h1);
    for (int b = 0; b < 10; b++)
      send(2'd2, mk_data(40 + b), b == 0, b == 9, (b == 9) ? 5'd5 : 5'd0, 1'b1);
    rd_chk("status_done", ADDR_STATUS, 32'h0012_0083);
    cap = mk_data(40);
    rd_chk("cap_b0_w0", 8'h40, cap[255:224]);
    rd_chk("cap_b0_w7", 8'h47, cap[31:0]);
    cap = mk_data(43);
    rd_chk("cap_b3_w2", 8'h5A, cap[191:160]);
    cap = mk_data(47);
    rd_chk("cap_b7_w7", 8'h7F, cap[31:0]);
    rd_chk("ctrl_done", ADDR_CTRL, 32'h24);
    rd_chk("errcnt_clean", ADDR_ERRCNT, 32'd0);

    // Protocol errors
    csr_wr(ADDR_CTRL, 32'h0);
    send(2'd3, mk_data(50), 1'b1, 1'b0, 5'd0, 1'b1);
    send(2'd3, mk_data(51), 1'b1, 1'b0, 5'd0, 1'b1);
    send(2'd3, mk_data(52), 1'b0, 1'b1, 5'd0, 1'b1);
    rd_chk("errcnt_double_sop", ADDR_ERRCNT, 32'd1);
    send(2'd3, mk_data(53), 1'b0, 1'b1, 5'd0, 1'b1);
    rd_chk("errcnt_orphan", ADDR_ERRCNT, 32'd2);

    // CLEAR coincident with an EOP
    send(2'd2, mk_data(60), 1'b1, 1'b0, 5'd0, 1'b1);
    present(2'd2, mk_data(61), 1'b0, 1'b1, 5'd0);
    csr_address   = ADDR_CLEAR;
    csr_writedata = 32'd0;
    csr_write     = 1'b1;
    wait_accept(1'b1);
    csr_write = 1'b0;
    rd_chk("clr_pkt2", 8'h06, 32'd0);
    rd_chk("clr_bytes2", 8'h0A, 32'd0);
    rd_chk("clr_errcnt", ADDR_ERRCNT, 32'd0);
    rd_chk("clr_pkt3", 8'h07, 32'd0);
    rd_chk("unmapped_30", 8'h30, 32'hFFFF_FFFF);
    rd_chk("unmapped_03", 8'h03, 32'hFFFF_FFFF);

    // Reset mid-packet
    send(2'd1, mk_data(70), 1'b1, 1'b0, 5'd0, 1'b1);
    idle(2);
    present(2'd1, mk_data(71), 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(st_in.ready), 32'd0);
    @(posedge clk);
    #1;
    st_in.valid = 1'b0;
    chk("midrst_out_valid", 32'(st_out.valid), 32'd0);
    chk("midrst_readdata", csr_readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    send(2'd1, mk_data(80), 1'b1, 1'b0, 5'd0, 1'b1);
    send(2'd1, mk_data(81), 1'b0, 1'b1, 5'd0, 1'b1);
    rd_chk("postrst_errcnt", ADDR_ERRCNT, 32'd0);
    rd_chk("postrst_pkt1", 8'h05, 32'd1);
    rd_chk("postrst_status", ADDR_STATUS, 32'd0);
    idle(3);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
